// File: rtl/mdu_hilo_ctrl_pkg.sv
// Shared op codes, FSM states and op-class helpers for the MDU/HI-LO sequencer.
package mdu_hilo_ctrl_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] NOP_CONTROL   = 5'd0;
  localparam logic [OP_W-1:0] MULT_CONTROL  = 5'd1;
  localparam logic [OP_W-1:0] MULTU_CONTROL = 5'd2;
  localparam logic [OP_W-1:0] DIV_CONTROL   = 5'd3;
  localparam logic [OP_W-1:0] DIVU_CONTROL  = 5'd4;
  localparam logic [OP_W-1:0] MTHI_CONTROL  = 5'd5;
  localparam logic [OP_W-1:0] MTLO_CONTROL  = 5'd6;
  localparam logic [OP_W-1:0] MFHI_CONTROL  = 5'd7;
  localparam logic [OP_W-1:0] MFLO_CONTROL  = 5'd8;
  localparam logic [OP_W-1:0] MADD_CONTROL  = 5'd9;
  localparam logic [OP_W-1:0] MADDU_CONTROL = 5'd10;
  localparam logic [OP_W-1:0] MSUB_CONTROL  = 5'd11;
  localparam logic [OP_W-1:0] MSUBU_CONTROL = 5'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_mult(input logic [OP_W-1:0] op);
    return (op == MULT_CONTROL) || (op == MULTU_CONTROL);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
  endfunction

  function automatic logic is_acc(input logic [OP_W-1:0] op);
    return (op == MADD_CONTROL) || (op == MADDU_CONTROL) ||
           (op == MSUB_CONTROL) || (op == MSUBU_CONTROL);
  endfunction

  function automatic logic is_sub(input logic [OP_W-1:0] op);
    return (op == MSUB_CONTROL) || (op == MSUBU_CONTROL);
  endfunction

  // The MDU only knows plain multiplies; accumulate variants reuse them.
  function automatic logic [OP_W-1:0] map_op(input logic [OP_W-1:0] op);
    logic [OP_W-1:0] m;
    m = op;
    if (op == MADD_CONTROL || op == MSUB_CONTROL)   m = MULT_CONTROL;
    if (op == MADDU_CONTROL || op == MSUBU_CONTROL) m = MULTU_CONTROL;
    return m;
  endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_hilo_regfile.sv
// Architectural HI/LO register pair with independent write enables.
module mdu_hilo_ctrl_hilo_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wd_hi,
  input  logic [31:0] wd_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  always_comb begin
    hi_d = we_hi ? wd_hi : hi_q;
    lo_d = we_lo ? wd_lo : lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// EX-stage sequencer for the MDU: issues ops, stalls on divides, commits HI/LO.
// Define HILO_ACC_EN to accept MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}).
module mdu_hilo_ctrl
  import mdu_hilo_ctrl_pkg::*;
#(
  parameter int OPW     = 5,
  parameter int DIV_MAX = 40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall_in,
  input  logic            ex_valid,
  input  logic [OPW-1:0]  ex_op,
  input  logic [31:0]     ex_rs,
  input  logic [63:0]     mdu_result,
  input  logic            mdu_ready,
  output logic [OPW-1:0]  mdu_control,
  output logic            mdu_en,
  output logic            mdu_clear,
  output logic            ex_stall,
  output logic [31:0]     hilo_rdata,
  output logic [31:0]     hi,
  output logic [31:0]     lo
);

  localparam int CW = $clog2(DIV_MAX + 1) + 1;

  state_e      state_q, state_d;
  logic [63:0] res_q, res_d;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;

  logic        live, op_mult, op_div, acc_op;
  logic [63:0] mult_val, cval;
  logic        commit, we_hi, we_lo;
  logic [31:0] wd_hi, wd_lo;

  always_comb begin
    acc_op   = 1'b0;
    mult_val = mdu_result;
`ifdef HILO_ACC_EN
    acc_op = is_acc(ex_op);
    if (acc_op)
      mult_val = is_sub(ex_op) ? ({hi, lo} - mdu_result) : ({hi, lo} + mdu_result);
`endif
  end

  always_comb begin
    live      = ex_valid & ~flush;
    op_mult   = is_mult(ex_op) | acc_op;
    op_div    = is_div(ex_op);
    state_d   = state_q;
    res_d     = res_q;
    ex_stall  = 1'b0;
    mdu_clear = 1'b0;
    commit    = 1'b0;
    cval      = res_q;
    unique case (state_q)
      S_IDLE: begin
        // A stalled mult just retries; the pipeline is already held downstream.
        if (live && op_mult && !stall_in) begin
          commit = 1'b1;
          cval   = mult_val;
        end else if (live && op_div) begin
          ex_stall = 1'b1;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        ex_stall = 1'b1;
        if (flush) begin
          mdu_clear = 1'b1;
          state_d   = S_IDLE;
        end else if (mdu_ready) begin
          res_d   = mdu_result;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ex_stall = stall_in;
        if (flush) begin
          state_d = S_IDLE;
        end else if (!stall_in) begin
          commit  = 1'b1;
          cval    = res_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_hi = commit | (live & ~stall_in & (ex_op == MTHI_CONTROL));
    we_lo = commit | (live & ~stall_in & (ex_op == MTLO_CONTROL));
    wd_hi = commit ? cval[63:32] : ex_rs;
    wd_lo = commit ? cval[31:0]  : ex_rs;
  end

  always_comb begin
    mdu_en      = ~stall_in;
    mdu_control = NOP_CONTROL;
    if (!rst && ex_valid && (op_mult || op_div))
      mdu_control = map_op(ex_op);
    hilo_rdata = 32'd0;
    if (ex_op == MFHI_CONTROL) hilo_rdata = hi;
    if (ex_op == MFLO_CONTROL) hilo_rdata = lo;
  end

  always_comb begin
    busy_cnt_d = '0;
    if (state_q == S_BUSY)
      busy_cnt_d = (busy_cnt_q == CW'(DIV_MAX)) ? busy_cnt_q : busy_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      res_q      <= '0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == S_BUSY)
      assert (busy_cnt_q < CW'(DIV_MAX));
  end

  mdu_hilo_ctrl_hilo_regfile u_regs (
    .clk   (clk),
    .rst   (rst),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .wd_hi (wd_hi),
    .wd_lo (wd_lo),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Directed bench for mdu_hilo_ctrl: mult/div sequencing, flush, stall, MT/MF ops.
module tb_mdu_hilo_ctrl;
  import mdu_hilo_ctrl_pkg::*;

  logic        clk, rst, flush, stall_in, ex_valid, mdu_ready;
  logic [4:0]  ex_op, mdu_control;
  logic [31:0] ex_rs, hilo_rdata, hi, lo;
  logic [63:0] mdu_result;
  logic        mdu_en, mdu_clear, ex_stall;

  int checks = 0;
  int errors = 0;

  mdu_hilo_ctrl #(.OPW(5), .DIV_MAX(40)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs),
    .mdu_result(mdu_result), .mdu_ready(mdu_ready),
    .mdu_control(mdu_control), .mdu_en(mdu_en), .mdu_clear(mdu_clear),
    .ex_stall(ex_stall), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1; flush = 0; stall_in = 0; ex_rs = '0;
    // MULT presented during reset must not reach the MDU or the registers
    ex_valid = 1; ex_op = MULT_CONTROL; mdu_result = 64'h1234_5678_9ABC_DEF0; mdu_ready = 1;
    repeat (3) step();
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", ex_stall, 0);
    chk("rst_ctl", mdu_control, 0);

    // MULT commits in one cycle, never stalls
    rst = 0; ex_op = MULT_CONTROL; mdu_result = 64'hFFFF_FFFF_FFFF_FFFA;
    #1;
    chk("mult_stall", ex_stall, 0);
    chk("mult_ctl", mdu_control, MULT_CONTROL);
    chk("mult_en", mdu_en, 1);
    step();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // MULT under downstream stall retries
    stall_in = 1; mdu_result = 64'h1111_2222_3333_4444;
    #1;
    chk("mults_stall", ex_stall, 0);
    chk("mults_en", mdu_en, 0);
    step();
    chk("mults_hold", hi, 32'hFFFF_FFFF);
    stall_in = 0;
    step();
    chk("mults_hi", hi, 32'h1111_2222);
    chk("mults_lo", lo, 32'h3333_4444);

    // DIVU: 33 stall cycles, ready in the last
    ex_op = DIVU_CONTROL; mdu_ready = 0; n = 0;
    for (int i = 0; i < 33; i++) begin
      mdu_ready  = (i == 32);
      mdu_result = (i == 32) ? 64'h0000_0001_0000_0003 : 64'h5555_5555_5555_5555;
      #1;
      if (ex_stall) n++;
      if (i == 0) chk("divu_ctl", mdu_control, DIVU_CONTROL);
      step();
    end
    mdu_ready = 0; mdu_result = 64'h6666_6666_6666_6666;
    #1;
    chk("divu_ncyc", n, 33);
    chk("divu_done_stall", ex_stall, 0);
    chk("divu_pre_hi", hi, 32'h1111_2222);
    step();
    ex_op = MFLO_CONTROL;
    #1;
    chk("divu_mflo", hilo_rdata, 3);
    chk("divu_hi", hi, 1);

    // DIV flushed at BUSY cycle 10
    ex_op = DIV_CONTROL;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 1) chk("fl_noclear", mdu_clear, 0);
      step();
    end
    flush = 1;
    #1;
    chk("fl_clear", mdu_clear, 1);
    chk("fl_stall", ex_stall, 1);
    step();
    flush = 0; ex_valid = 0;
    #1;
    chk("fl_clear_pulse", mdu_clear, 0);
    chk("fl_idle", ex_stall, 0);
    chk("fl_hi", hi, 1);
    chk("fl_lo", lo, 3);

    // flush coincident with ready: flush wins
    ex_valid = 1; ex_op = DIV_CONTROL;
    step(); step();
    flush = 1; mdu_ready = 1; mdu_result = 64'h0000_0009_0000_0009;
    #1;
    chk("flr_clear", mdu_clear, 1);
    step();
    flush = 0; ex_valid = 0; mdu_ready = 0;
    step();
    chk("flr_hi", hi, 1);
    chk("flr_lo", lo, 3);

    // DIV ready while stalled: DONE held for 4 cycles, one commit
    ex_valid = 1; ex_op = DIV_CONTROL;
    step(); step();
    stall_in = 1; mdu_ready = 1; mdu_result = 64'hAAAA_0001_BBBB_0002;
    #1;
    chk("dst_stall", ex_stall, 1);
    step();
    mdu_ready = 0; mdu_result = 64'h7777_7777_7777_7777; n = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ex_stall && hi == 32'd1) n++;
      step();
    end
    chk("dst_held", n, 4);
    stall_in = 0;
    #1;
    chk("dst_release", ex_stall, 0);
    step();
    ex_op = MULT_CONTROL; stall_in = 1;
    #1;
    chk("dst_hi", hi, 32'hAAAA_0001);
    chk("dst_lo", lo, 32'hBBBB_0002);
    chk("dst_idle", ex_stall, 0);
    step();
    stall_in = 0;

    // MTHI / MFHI / MTLO under stall
    ex_op = MTHI_CONTROL; ex_rs = 32'hDEAD_BEEF;
    #1;
    chk("mthi_rdata0", hilo_rdata, 0);
    step();
    ex_op = MFHI_CONTROL;
    #1;
    chk("mfhi", hilo_rdata, 32'hDEAD_BEEF);
    chk("mthi_lo", lo, 32'hBBBB_0002);
    ex_op = MTLO_CONTROL; ex_rs = 32'h1234_5678; stall_in = 1;
    step();
    stall_in = 0;
    #1;
    chk("mtlo_stalled", lo, 32'hBBBB_0002);
    step();
    ex_op = MFLO_CONTROL;
    #1;
    chk("mflo", hilo_rdata, 32'h1234_5678);
    ex_op = 5'd31;
    #1;
    chk("other_ctl", mdu_control, 0);
    chk("other_rdata", hilo_rdata, 0);
    ex_valid = 0; ex_op = MULT_CONTROL;
    #1;
    chk("novalid_ctl", mdu_control, 0);

`ifdef HILO_ACC_EN
    ex_valid = 1; ex_op = MTHI_CONTROL; ex_rs = 32'h0;
    step();
    ex_op = MTLO_CONTROL; ex_rs = 32'hFFFF_FFFF;
    step();
    ex_op = MADDU_CONTROL; mdu_result = 64'd1;
    #1;
    chk("maddu_ctl", mdu_control, MULTU_CONTROL);
    step();
    chk("maddu_hi", hi, 1);
    chk("maddu_lo", lo, 0);
    ex_op = MSUB_CONTROL; mdu_result = 64'd1;
    #1;
    chk("msub_ctl", mdu_control, MULT_CONTROL);
    step();
    chk("msub_hi", hi, 0);
    chk("msub_lo", lo, 32'hFFFF_FFFF);
`else
    ex_valid = 1; ex_op = MADDU_CONTROL; mdu_result = 64'd1;
    #1;
    chk("maddu_off_ctl", mdu_control, 0);
    chk("maddu_off_stall", ex_stall, 0);
    step();
    chk("maddu_off_hi", hi, 32'hDEAD_BEEF);
    chk("maddu_off_lo", lo, 32'h1234_5678);
`endif
    ex_valid = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
